// File: rtl/arb_pkg.sv
// Shared types and sizing for the round-robin memory arbiter.
// Used by mem_arbiter_rr and rr_picker; see rr_picker for ARB_FIXED_PRIORITY_EN.
package arb_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    localparam int unsigned MAX_CH = 8;
    // Channel indices are sized for the largest supported configuration.
    localparam int unsigned IDX_W  = $clog2(MAX_CH);

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection for the memory arbiter.
// Round-robin from last+1 by default; ARB_FIXED_PRIORITY_EN selects lowest index instead.
module rr_picker
    import arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic [IDX_W-1:0]  winner,
    output logic              any_req
);

    assign any_req = |req;

`ifdef ARB_FIXED_PRIORITY_EN
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = IDX_W'(i);
            end
        end
    end
`else
    always_comb begin
        logic found;
        int   idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        // Search upward from the channel after the last winner, wrapping.
        for (int off = 1; off <= int'(NUM_CH); off++) begin
            idx = (int'(last) + off) % int'(NUM_CH);
            if (!found && req[idx]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel arbiter onto a single cacheline memory port; grant held until mem_resp.
// Define ARB_FIXED_PRIORITY_EN to make channel 0 always win arbitration.
module mem_arbiter_rr
    import arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [NUM_CH*DATA_W-1:0] ch_rdata,
    input  logic                     mem_resp,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_wdata
);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, last_q, winner;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [DATA_W-1:0] wdata_q, sel_wdata;
    logic              op_q, sel_write;
    logic [NUM_CH-1:0] req;
    logic              any_req;

    assign req = ch_read | ch_write;

    rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .req     (req),
        .last    (last_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (int'(winner) == i) begin
                sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
                sel_write = ch_write[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (any_req) state_d = BUSY;
            BUSY: if (mem_resp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_CH - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= 1'b0;
        end else if (state_q == IDLE && any_req) begin
            grant_q <= winner;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            op_q    <= sel_write;
        end else if (state_q == BUSY && mem_resp) begin
            last_q  <= grant_q;
        end
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        ch_resp     = '0;
        ch_rdata    = '0;
        if (state_q == BUSY) begin
            mem_read    = !op_q;
            mem_write   = op_q;
            mem_address = addr_q;
            mem_wdata   = op_q ? wdata_q : '0;
            // A response landing in a reset cycle belongs to an abandoned transaction.
            if (mem_resp && !rst) begin
                for (int i = 0; i < int'(NUM_CH); i++) begin
                    if (int'(grant_q) == i) begin
                        ch_resp[i]                    = 1'b1;
                        ch_rdata[i*DATA_W +: DATA_W]  = mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- N-channel arbiter between cache-side memory ports (I-cache, D-cache, later prefetch/victim buffer) and the single cacheline physical-memory port.
- Generalises the two-port fixed-priority cache arbiter:
  - parametrised channel count and widths;
  - round-robin fairness;
  - registered grant that is held for the whole transaction until mem_resp;
  - request, address and write data latched at grant.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8).
- DATA_W, 256, cacheline width in bits.
- ADDR_W, 32, address width in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- ch_read  in  NUM_CH  per-channel read request, level, held until ch_resp.
- ch_write  in  NUM_CH  per-channel write request, level, held until ch_resp.
- ch_addr  in  NUM_CH*ADDR_W  per-channel line address; channel i in bits [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*DATA_W  per-channel write line; same packing.
- ch_resp  out  NUM_CH  one-cycle completion pulse to the granted channel.
- ch_rdata  out  NUM_CH*DATA_W  read line to the granted channel; zero for all others.
- mem_resp  in  1  memory completion pulse.
- mem_rdata  in  DATA_W  memory read line.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write line.

Interface rules: one clock, clk. Reset is rst: synchronous, active-high.

Behaviour:
- Reset:
  - state=IDLE; grant_q=0; last_q=NUM_CH-1, so channel 0 wins first.
  - mem_read, mem_write, mem_address, mem_wdata, ch_resp and ch_rdata are all 0.
  - A reset mid-transaction abandons the transaction. Memory strobes are low from the next cycle, and no ch_resp is issued.
- Request per channel: req[i] = ch_read[i] | ch_write[i].
- State IDLE:
  - If any req bit is set, pick the winner by round-robin: the first set bit searching upward from last_q+1, wrapping modulo NUM_CH.
  - Register grant_q=winner, addr_q, wdata_q and op_q (1 = write).
  - If ch_read and ch_write are both high on the winner, the write wins.
  - Go to BUSY.
  - If no req bit is set, stay in IDLE.
- State BUSY:
  - mem_read = !op_q; mem_write = op_q; mem_address = addr_q; mem_wdata = op_q ? wdata_q : 0. All driven from registers.
  - When mem_resp is high, in the same cycle (combinational):
    - ch_resp[grant_q] = 1;
    - ch_rdata slice grant_q = mem_rdata.
  - On the next edge: last_q = grant_q and state goes to IDLE.
- Latency: request seen in IDLE at cycle t; mem strobe asserted at t+1; ch_resp in the same cycle as mem_resp.
- There is a minimum of one IDLE cycle between transactions. Requesters therefore drop their request after ch_resp before the next arbitration.
- If the requester deasserts its request while BUSY, the transaction still completes and ch_resp still pulses.
- Changes to the latched channel's addr or wdata while BUSY are ignored.
- mem_resp while IDLE is ignored, and no ch_resp is issued.
- Requests arriving while BUSY wait; no request is dropped.
- Starvation bound: a held request is served within NUM_CH transactions.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- Defined: the IDLE pick is the lowest-index requesting channel (channel 0 highest, the I-cache first). last_q is still maintained but unused.
- Undefined: round-robin as specified above.
- All other timing is identical in both modes.

Decomposition:
- Package arb_pkg:
  - arb_state_t enum {IDLE, BUSY};
  - localparams for the maximum channel count and clog2-based grant index width.
- Sub-module rr_picker:
  - purely combinational;
  - inputs: req vector, last index;
  - outputs: winner index, any_req;
  - contains the fixed-priority ifdef.
- The arbiter holds the FSM and the datapath registers.

Test Plan:
- Single read, NUM_CH=2:
  - ch_read[1]=1, addr 0x0000_1000; memory responds 3 cycles after mem_read.
  - Required: mem_read rises the cycle after the request, mem_address=0x1000, ch_resp[1] pulses once, ch_rdata slice 1 = mem_rdata, slice 0 = 0.
- Write with data latch:
  - ch_write[0]=1, wdata=0xA5 repeated; change ch_wdata mid-BUSY.
  - Required: mem_wdata stays 0xA5…, mem_write=1, mem_read=0.
- Contention fairness, NUM_CH=4:
  - All four channels hold read continuously.
  - Required: grants go 0,1,2,3,0…, with one IDLE cycle between transactions.
  - With ARB_FIXED_PRIORITY_EN: channel 0 always wins.
- Simultaneous read and write on one channel:
  - ch_read[2]=ch_write[2]=1.
  - Required: mem_write=1, mem_read=0.
- Reset mid-BUSY:
  - Assert rst for 1 cycle while mem_read=1.
  - Required: mem_read=0 the next cycle, no ch_resp pulse, then channel 0 is granted first.
- Spurious response:
  - mem_resp=1 while IDLE.
  - Required: ch_resp stays 0 and state stays IDLE.
